// File: rtl/alu_pkg.sv
// Shared types for the ALU response checker.
// Opcode encodings and checker state encoding.
package alu_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 2'b00;
  localparam alu_op_t ALU_SUB = 2'b01;
  localparam alu_op_t ALU_AND = 2'b10;
  localparam alu_op_t ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } chk_state_t;

endpackage

// File: rtl/alu_resp_checker_if.sv
// Observed ALU vector bus: operands, opcode, result, carry.
// master drives the vectors, slave samples them.
interface alu_resp_checker_if #(
  parameter int WIDTH = 16
);
  import alu_pkg::*;

  logic             in_valid;
  alu_op_t          in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_o;
  logic             in_cout;

  modport master (
    output in_valid, in_op, in_a,
    output in_b, in_o, in_cout
  );

  modport slave (
    input in_valid, in_op, in_a,
    input in_b, in_o, in_cout
  );

endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden ALU used to predict result and carry.
// SUB carry is the a + ~b + 1 carry, so 1 means no borrow.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_o,
  output logic             exp_cout
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = '0;
    exp_o    = '0;
    exp_cout = 1'b0;
    unique case (op)
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        exp_o    = sum[WIDTH-1:0];
        exp_cout = sum[WIDTH];
      end
      ALU_SUB: begin
        sum      = {1'b0, a} + {1'b0, ~b}
                 + {{WIDTH{1'b0}}, 1'b1};
        exp_o    = sum[WIDTH-1:0];
        exp_cout = sum[WIDTH];
      end
      ALU_AND: exp_o = a & b;
      ALU_OR:  exp_o = a | b;
    endcase
  end

endmodule

// File: rtl/alu_resp_checker.sv
// Two-stage ALU response checker with saturating statistics,
// first-failure capture and completion after EXP_COUNT vectors.
module alu_resp_checker
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 8,
  parameter int EXP_COUNT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  alu_resp_checker_if.slave vec,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              ff_valid,
  output logic [CNT_W-1:0]  ff_idx,
  output alu_op_t           ff_op,
  output logic [WIDTH-1:0]  ff_exp,
  output logic [WIDTH-1:0]  ff_got,
  output logic              done,
  output logic              all_pass,
  output logic              overrun
);

  // Completion count is kept wider than the saturating counters.
  localparam int CHK_A = CNT_W + 1;
  localparam int CHK_B = $clog2(EXP_COUNT + 1);
  localparam int CHK_W = (CHK_A > CHK_B) ? CHK_A : CHK_B;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CHK_W-1:0] CHK_TGT = CHK_W'(EXP_COUNT);

  chk_state_t state_q;
  chk_state_t state_d;

  logic [CNT_W-1:0] idx_q;
  logic [CHK_W-1:0] chk_q;

  logic             s1_valid;
  alu_op_t          s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_o;
  logic             s1_cout;
  logic [CNT_W-1:0] s1_idx;

  logic             s2_valid;
  logic             s2_match;
  alu_op_t          s2_op;
  logic [WIDTH-1:0] s2_exp;
  logic [WIDTH-1:0] s2_got;
  logic [CNT_W-1:0] s2_idx;

  logic [WIDTH-1:0] exp_o;
  logic             exp_cout;
  logic             accept;
  logic             commit;

  assign accept = vec.in_valid && (state_q != DONE);
  assign commit = s2_valid && (state_q == RUN);

  alu_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .op      (s1_op),
    .a       (s1_a),
    .b       (s1_b),
    .exp_o   (exp_o),
    .exp_cout(exp_cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (vec.in_valid) state_d = RUN;
      RUN: begin
        if (commit && (chk_q + CHK_W'(1) == CHK_TGT))
          state_d = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= ALU_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_o     <= '0;
      s1_cout  <= 1'b0;
      s1_idx   <= '0;
      idx_q    <= '0;
      s2_valid <= 1'b0;
      s2_match <= 1'b0;
      s2_op    <= ALU_ADD;
      s2_exp   <= '0;
      s2_got   <= '0;
      s2_idx   <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      idx_q    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op   <= vec.in_op;
        s1_a    <= vec.in_a;
        s1_b    <= vec.in_b;
        s1_o    <= vec.in_o;
        s1_cout <= vec.in_cout;
        s1_idx  <= idx_q;
        if (idx_q != CNT_MAX)
          idx_q <= idx_q + CNT_W'(1);
      end
      s2_valid <= s1_valid;
      s2_match <= (s1_o == exp_o)
               && (s1_cout == exp_cout);
      s2_op    <= s1_op;
      s2_exp   <= exp_o;
      s2_got   <= s1_o;
      s2_idx   <= s1_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q    <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_op    <= ALU_ADD;
      ff_exp   <= '0;
      ff_got   <= '0;
      overrun  <= 1'b0;
    end else if (clr) begin
      chk_q    <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_op    <= ALU_ADD;
      ff_exp   <= '0;
      ff_got   <= '0;
      overrun  <= 1'b0;
    end else begin
      if (vec.in_valid && (state_q == DONE))
        overrun <= 1'b1;
      if (commit) begin
        chk_q <= chk_q + CHK_W'(1);
        if (s2_match) begin
          if (pass_cnt != CNT_MAX)
            pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != CNT_MAX)
            fail_cnt <= fail_cnt + CNT_W'(1);
          if (!ff_valid) begin
            ff_valid <= 1'b1;
            ff_idx   <= s2_idx;
            ff_op    <= s2_op;
            ff_exp   <= s2_exp;
            ff_got   <= s2_got;
          end
        end
      end
    end
  end

  assign done     = (state_q == DONE);
  assign all_pass = done && (fail_cnt == '0);

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed bench for alu_resp_checker with a queue-based model.
// A second instance exercises counter saturation.
module tb_alu_resp_checker;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_clr [2];
  logic s_valid [2];
  logic [1:0] s_op [2];
  logic [15:0] s_a [2];
  logic [15:0] s_b [2];
  logic [15:0] s_o [2];
  logic s_c [2];

  always #5 clk = ~clk;

  alu_resp_checker_if #(.WIDTH(16)) if0 ();
  alu_resp_checker_if #(.WIDTH(16)) if1 ();

  assign if0.in_valid = s_valid[0];
  assign if0.in_op    = s_op[0];
  assign if0.in_a     = s_a[0];
  assign if0.in_b     = s_b[0];
  assign if0.in_o     = s_o[0];
  assign if0.in_cout  = s_c[0];
  assign if1.in_valid = s_valid[1];
  assign if1.in_op    = s_op[1];
  assign if1.in_a     = s_a[1];
  assign if1.in_b     = s_b[1];
  assign if1.in_o     = s_o[1];
  assign if1.in_cout  = s_c[1];

  logic [7:0] pass0, fail0, idx0;
  logic [3:0] pass1, fail1, idx1;
  logic ffv0, ffv1, done0, done1;
  logic ap0, ap1, ovr0, ovr1;
  alu_op_t op0, op1;
  logic [15:0] fexp0, fgot0, fexp1, fgot1;

  alu_resp_checker #(
    .WIDTH(16), .CNT_W(8), .EXP_COUNT(16)
  ) dut0 (
    .clk(clk), .reset(reset), .clr(s_clr[0]),
    .vec(if0.slave),
    .pass_cnt(pass0), .fail_cnt(fail0),
    .ff_valid(ffv0), .ff_idx(idx0), .ff_op(op0),
    .ff_exp(fexp0), .ff_got(fgot0),
    .done(done0), .all_pass(ap0), .overrun(ovr0)
  );

  alu_resp_checker #(
    .WIDTH(16), .CNT_W(4), .EXP_COUNT(20)
  ) dut1 (
    .clk(clk), .reset(reset), .clr(s_clr[1]),
    .vec(if1.slave),
    .pass_cnt(pass1), .fail_cnt(fail1),
    .ff_valid(ffv1), .ff_idx(idx1), .ff_op(op1),
    .ff_exp(fexp1), .ff_got(fgot1),
    .done(done1), .all_pass(ap1), .overrun(ovr1)
  );

  // Directed vectors with hand-computed correct responses.
  logic [1:0] t_op [16] = '{0,0,0,0,1,1,1,1,
                             2,2,2,2,3,3,3,3};
  logic [15:0] t_a [16] = '{
    16'h0000, 16'haa55, 16'hffff, 16'h0001,
    16'h0000, 16'haa55, 16'hffff, 16'h0001,
    16'h0000, 16'haa55, 16'hffff, 16'h0001,
    16'h0000, 16'haa55, 16'hffff, 16'h0001};
  logic [15:0] t_b [16] = '{
    16'h0000, 16'h55aa, 16'h0001, 16'h7fff,
    16'h0000, 16'h55aa, 16'h0001, 16'h7fff,
    16'h0000, 16'h55aa, 16'h0001, 16'h7fff,
    16'h0000, 16'h55aa, 16'h0001, 16'h7fff};
  logic [15:0] t_o [16] = '{
    16'h0000, 16'hffff, 16'h0000, 16'h8000,
    16'h0000, 16'h54ab, 16'hfffe, 16'h8002,
    16'h0000, 16'h0000, 16'h0001, 16'h0001,
    16'h0000, 16'hffff, 16'hffff, 16'h7fff};
  logic t_c [16] = '{0,0,1,0, 1,1,1,0,
                     0,0,0,0, 0,0,0,0};

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 0;

  task automatic chk(string nm,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  // Model: each accepted vector becomes due two edges later.
  typedef struct {
    int due; int idx; int op;
    int a; int b; int o; int c;
  } vec_t;

  vec_t q0 [$];
  vec_t q1 [$];
  int cyc = 0;
  int cnt_max [2] = '{255, 15};
  int exp_n [2] = '{16, 20};
  int m_pass [2], m_fail [2], m_ffv [2];
  int m_fidx [2], m_fop [2], m_fexp [2];
  int m_fgot [2], m_done [2], m_ovr [2];
  int m_chk [2], m_idx [2];

  task automatic m_clear(int d);
    m_pass[d] = 0; m_fail[d] = 0; m_ffv[d] = 0;
    m_fidx[d] = 0; m_fop[d] = 0; m_fexp[d] = 0;
    m_fgot[d] = 0; m_done[d] = 0; m_ovr[d] = 0;
    m_chk[d] = 0; m_idx[d] = 0;
    if (d == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic m_commit(int d, vec_t v);
    int eo, ec;
    case (v.op)
      0: begin
        eo = (v.a + v.b) % 65536;
        ec = (v.a + v.b >= 65536) ? 1 : 0;
      end
      1: begin
        eo = (v.a - v.b + 65536) % 65536;
        ec = (v.a >= v.b) ? 1 : 0;
      end
      2: begin eo = v.a & v.b; ec = 0; end
      default: begin eo = v.a | v.b; ec = 0; end
    endcase
    m_chk[d]++;
    if (v.o == eo && v.c == ec) begin
      if (m_pass[d] < cnt_max[d]) m_pass[d]++;
    end else begin
      if (m_fail[d] < cnt_max[d]) m_fail[d]++;
      if (m_ffv[d] == 0) begin
        m_ffv[d] = 1; m_fidx[d] = v.idx;
        m_fop[d] = v.op; m_fexp[d] = eo;
        m_fgot[d] = v.o;
      end
    end
    if (m_chk[d] == exp_n[d]) m_done[d] = 1;
  endtask

  task automatic m_step(int d);
    int was_done;
    vec_t v;
    was_done = m_done[d];
    if (s_clr[d]) begin
      m_clear(d);
    end else begin
      if (d == 0) begin
        while (q0.size() > 0 && q0[0].due <= cyc) begin
          v = q0.pop_front();
          if (was_done == 0) m_commit(0, v);
        end
      end else begin
        while (q1.size() > 0 && q1[0].due <= cyc) begin
          v = q1.pop_front();
          if (was_done == 0) m_commit(1, v);
        end
      end
      if (s_valid[d]) begin
        if (was_done != 0) begin
          m_ovr[d] = 1;
        end else begin
          v.due = cyc + 2; v.idx = m_idx[d];
          v.op = int'(s_op[d]); v.a = int'(s_a[d]);
          v.b = int'(s_b[d]); v.o = int'(s_o[d]);
          v.c = int'(s_c[d]);
          if (d == 0) q0.push_back(v);
          else q1.push_back(v);
          if (m_idx[d] < cnt_max[d]) m_idx[d]++;
        end
      end
    end
  endtask

  initial begin
    m_clear(0);
    m_clear(1);
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_clear(0);
        m_clear(1);
      end else begin
        cyc++;
        m_step(0);
        m_step(1);
      end
    end
  end

  task automatic cmp_all();
    chk("d0.pass", pass0, m_pass[0]);
    chk("d0.fail", fail0, m_fail[0]);
    chk("d0.ffv", ffv0, m_ffv[0]);
    chk("d0.fidx", idx0, m_fidx[0]);
    chk("d0.fop", op0, m_fop[0]);
    chk("d0.fexp", fexp0, m_fexp[0]);
    chk("d0.fgot", fgot0, m_fgot[0]);
    chk("d0.done", done0, m_done[0]);
    chk("d0.allp", ap0,
        (m_done[0] != 0 && m_fail[0] == 0) ? 1 : 0);
    chk("d0.ovr", ovr0, m_ovr[0]);
    chk("d1.pass", pass1, m_pass[1]);
    chk("d1.fail", fail1, m_fail[1]);
    chk("d1.ffv", ffv1, m_ffv[1]);
    chk("d1.fidx", idx1, m_fidx[1]);
    chk("d1.done", done1, m_done[1]);
    chk("d1.allp", ap1,
        (m_done[1] != 0 && m_fail[1] == 0) ? 1 : 0);
    chk("d1.ovr", ovr1, m_ovr[1]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) cmp_all();
    end
  end

  task automatic send(int d, int i, bit bo, bit bc);
    @(negedge clk);
    s_valid[d] = 1'b1;
    s_op[d] = t_op[i];
    s_a[d] = t_a[i];
    s_b[d] = t_b[i];
    s_o[d] = bo ? (t_o[i] ^ 16'h0001) : t_o[i];
    s_c[d] = bc ? ~t_c[i] : t_c[i];
  endtask

  task automatic idle(int d);
    @(negedge clk);
    s_valid[d] = 1'b0;
  endtask

  task automatic zero_chk(string nm, int d);
    if (d == 0) begin
      chk({nm, ".pass"}, pass0, 0);
      chk({nm, ".fail"}, fail0, 0);
      chk({nm, ".ffv"}, ffv0, 0);
      chk({nm, ".done"}, done0, 0);
      chk({nm, ".ovr"}, ovr0, 0);
    end else begin
      chk({nm, ".pass1"}, pass1, 0);
      chk({nm, ".done1"}, done1, 0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_clr[d] = 0; s_valid[d] = 0; s_op[d] = 0;
      s_a[d] = 0; s_b[d] = 0; s_o[d] = 0; s_c[d] = 0;
    end
    #1 reset = 1'b1;
    #1;
    zero_chk("rst", 0);
    zero_chk("rst", 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1;

    // All-pass run; done lands two edges after last vector.
    for (int i = 0; i < 16; i++) send(0, i, 0, 0);
    idle(0);
    chk("lit.done_early", done0, 0);
    @(negedge clk);
    chk("lit.done_n1", done0, 0);
    @(negedge clk);
    chk("lit.done", done0, 1);
    chk("lit.pass16", pass0, 16);
    chk("lit.allpass", ap0, 1);

    // Overrun after done.
    send(0, 3, 0, 0);
    idle(0);
    chk("lit.ovr", ovr0, 1);
    repeat (2) @(negedge clk);
    chk("lit.ovr_pass", pass0, 16);
    chk("lit.ovr_fail", fail0, 0);

    @(negedge clk) s_clr[0] = 1'b1;
    @(negedge clk) s_clr[0] = 1'b0;
    zero_chk("clr", 0);

    // Result error at vector 5, carry error at vector 9.
    for (int i = 0; i < 16; i++)
      send(0, i, i == 5, i == 9);
    idle(0);
    repeat (2) @(negedge clk);
    chk("lit.fail2", fail0, 2);
    chk("lit.pass14", pass0, 14);
    chk("lit.fidx", idx0, 5);
    chk("lit.fop", op0, 1);
    chk("lit.fexp", fexp0, 16'h54ab);
    chk("lit.fgot", fgot0, 16'h54aa);
    chk("lit.allp0", ap0, 0);
    chk("lit.done2", done0, 1);

    @(negedge clk) s_clr[0] = 1'b1;
    @(negedge clk) s_clr[0] = 1'b0;

    // Clear together with a vector while two are in flight.
    send(0, 1, 0, 0);
    send(0, 2, 0, 0);
    send(0, 3, 0, 0);
    s_clr[0] = 1'b1;
    @(negedge clk);
    s_clr[0] = 1'b0;
    s_valid[0] = 1'b0;
    zero_chk("clrv", 0);
    repeat (3) @(negedge clk);
    zero_chk("clrv_late", 0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 6; i++) send(0, i, 0, i == 2);
    idle(0);
    repeat (2) @(negedge clk);
    chk("lit.pre_rst_pass", pass0, 5);
    chk("lit.pre_rst_ffv", ffv0, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    zero_chk("arst", 0);
    @(negedge clk) reset = 1'b0;

    // Saturation instance: 20 passing vectors, 4-bit counters.
    for (int i = 0; i < 20; i++) send(1, i % 16, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit.sat_done_n1", done1, 0);
    @(negedge clk);
    chk("lit.sat_pass", pass1, 15);
    chk("lit.sat_done", done1, 1);
    chk("lit.sat_allp", ap1, 1);
    chk("lit.sat_fail", fail1, 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
